// File: rtl/aes128_ctrl_pkg.sv
// Shared types for the AES-128 stream controller: FSM states, mode bits, block width.
package aes128_ctrl_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_KEY  = 3'd1,
    ST_WAIT_IN   = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_OUTPUT    = 3'd5
  } state_t;

  typedef struct packed {
    logic decrypt;
    logic cbc;
  } mode_t;

endpackage

// File: rtl/aes_timeout_cnt.sv
// Core-completion watchdog: loaded on clear, counts down while enabled,
// expire is asserted on the TIMEOUT_CYCLES-th enabled cycle after clear.
module aes_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= LOAD_VAL;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/aes128_stream_ctrl.sv
// Streams 128-bit blocks through the AES-128 core one at a time, with optional
// CBC chaining and valid/ready handshakes on both sides.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for configuration, cfg_ready_o=1
// LOAD_KEY  | waiting for core_ready_i, then load_key pulse with key
// WAIT_IN   | in_ready_o=1, latching the next input block
// ISSUE     | waiting for core_ready_i, then start_enc/start_dec pulse
// WAIT_DONE | waiting for core_done_i, watchdog running
// OUTPUT    | out_valid_o=1 until out_ready_i
module aes128_stream_ctrl
  import aes128_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid_i,
  input  logic [AES_BLK_W-1:0] cfg_key_i,
  input  logic [AES_BLK_W-1:0] cfg_iv_i,
  input  logic                 cfg_decrypt_i,
  input  logic                 cfg_cbc_i,
  output logic                 cfg_ready_o,
  input  logic                 in_valid_i,
  input  logic [AES_BLK_W-1:0] in_data_i,
  input  logic                 in_last_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  output logic [AES_BLK_W-1:0] out_data_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic                 core_load_key_o,
  output logic                 core_start_enc_o,
  output logic                 core_start_dec_o,
  output logic [AES_BLK_W-1:0] core_data_o,
  input  logic [AES_BLK_W-1:0] core_data_i,
  input  logic                 core_ready_i,
  input  logic                 core_done_i,
  output logic                 busy_o,
  output logic                 err_timeout_o,
  output logic [CNT_W-1:0]     blk_count_o
);

  state_t               state_q, state_d;
  mode_t                mode_q;
  logic [AES_BLK_W-1:0] key_q, chain_q, raw_q, blk_q, res_q;
  logic                 last_q, err_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 tmr_expire;

  aes_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_ISSUE),
    .enable (state_q == ST_WAIT_DONE),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    cfg_ready_o      = 1'b0;
    in_ready_o       = 1'b0;
    out_valid_o      = 1'b0;
    out_data_o       = '0;
    out_last_o       = 1'b0;
    core_load_key_o  = 1'b0;
    core_start_enc_o = 1'b0;
    core_start_dec_o = 1'b0;
    core_data_o      = '0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) state_d = ST_LOAD_KEY;
      end
      ST_LOAD_KEY: begin
        core_data_o = key_q;
        if (core_ready_i) begin
          core_load_key_o = 1'b1;
          state_d         = ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        core_data_o = blk_q;
        if (core_ready_i) begin
          core_start_enc_o = !mode_q.decrypt;
          core_start_dec_o = mode_q.decrypt;
          state_d          = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // Completion takes priority over a watchdog expiring in the same cycle.
        if (core_done_i)     state_d = ST_OUTPUT;
        else if (tmr_expire) state_d = ST_IDLE;
      end
      ST_OUTPUT: begin
        out_valid_o = 1'b1;
        out_data_o  = res_q;
        out_last_o  = last_q;
        if (out_ready_i) state_d = last_q ? ST_IDLE : ST_WAIT_IN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      key_q   <= '0;
      chain_q <= '0;
      raw_q   <= '0;
      blk_q   <= '0;
      res_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            key_q          <= cfg_key_i;
            chain_q        <= cfg_iv_i;
            mode_q.decrypt <= cfg_decrypt_i;
            mode_q.cbc     <= cfg_cbc_i;
            cnt_q          <= '0;
            err_q          <= 1'b0;
          end
        end
        ST_WAIT_IN: begin
          if (in_valid_i) begin
            raw_q  <= in_data_i;
            last_q <= in_last_i;
            blk_q  <= (mode_q.cbc && !mode_q.decrypt) ? (in_data_i ^ chain_q) : in_data_i;
          end
        end
        ST_WAIT_DONE: begin
          if (core_done_i) begin
            res_q   <= (mode_q.cbc && mode_q.decrypt) ? (core_data_i ^ chain_q) : core_data_i;
            chain_q <= mode_q.decrypt ? raw_q : core_data_i;
          end else if (tmr_expire) begin
            err_q <= 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (out_ready_i) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign err_timeout_o = err_q;
  assign blk_count_o   = cnt_q;

endmodule

// File: tb/tb_aes128_stream_ctrl.sv
// Scoreboard bench for aes128_stream_ctrl with a behavioural AES core model
// (known FIPS/SP800-38A vectors by table, an invertible toy cipher otherwise).
module tb_aes128_stream_ctrl;

  localparam int T     = 64;
  localparam int CNT_W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid_i;
  logic [127:0] cfg_key_i, cfg_iv_i;
  logic         cfg_decrypt_i, cfg_cbc_i, cfg_ready_o;
  logic         in_valid_i;
  logic [127:0] in_data_i;
  logic         in_last_i, in_ready_o;
  logic         out_valid_o;
  logic [127:0] out_data_o;
  logic         out_last_o, out_ready_i;
  logic         core_load_key_o, core_start_enc_o, core_start_dec_o;
  logic [127:0] core_data_o, core_data_i;
  logic         core_ready_i, core_done_i;
  logic         busy_o, err_timeout_o;
  logic [CNT_W-1:0] blk_count_o;

  aes128_stream_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid_i), .cfg_key_i(cfg_key_i), .cfg_iv_i(cfg_iv_i),
    .cfg_decrypt_i(cfg_decrypt_i), .cfg_cbc_i(cfg_cbc_i), .cfg_ready_o(cfg_ready_o),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_last_i(in_last_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o), .out_ready_i(out_ready_i),
    .core_load_key_o(core_load_key_o), .core_start_enc_o(core_start_enc_o),
    .core_start_dec_o(core_start_dec_o), .core_data_o(core_data_o), .core_data_i(core_data_i),
    .core_ready_i(core_ready_i), .core_done_i(core_done_i),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o), .blk_count_o(blk_count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Known-answer table for the cipher model
  logic [127:0] vk[$], vin[$], vout[$];
  bit           vdec[$];

  task automatic add_vec(input logic [127:0] k, input logic [127:0] x, input bit dec, input logic [127:0] y);
    vk.push_back(k); vin.push_back(x); vdec.push_back(dec); vout.push_back(y);
  endtask

  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] x, input bit dec);
    logic [127:0] y;
    for (int i = 0; i < vk.size(); i++)
      if (vk[i] == k && vin[i] == x && vdec[i] == dec) return vout[i];
    if (!dec) begin
      y = x;
      return {y[63:0], y[127:64]} ^ k;
    end
    y = x ^ k;
    return {y[63:0], y[127:64]};
  endfunction

  // ---------------- core model ----------------
  bit           hang = 0, inject = 0;
  int           lat_force = 0;
  int           start_cyc = -1, n_starts = 0;
  logic [127:0] core_key = '0;

  initial begin
    bit           busy, nd;
    int           lat;
    logic [127:0] pend, ndat;
    busy = 0; lat = 0; pend = '0;
    core_ready_i = 1'b1; core_done_i = 1'b0; core_data_i = '0;
    forever begin
      @(negedge clk);
      nd = 0; ndat = '0;
      if (rst) begin
        busy = 0;
      end else begin
        if (core_load_key_o) core_key = core_data_o;
        if (core_start_enc_o || core_start_dec_o) begin
          busy = 1; start_cyc = cyc; n_starts++;
          lat  = (lat_force > 0) ? lat_force : int'($urandom_range(1, 5));
          pend = cipher(core_key, core_data_o, core_start_dec_o);
        end else if (busy) begin
          lat--;
          if (lat == 0) begin
            busy = 0;
            if (!hang) begin nd = 1; ndat = pend; end
          end
        end
      end
      if (inject) begin inject = 0; nd = 1; ndat = rnd128(); end
      @(posedge clk); #1;
      core_ready_i = !busy;
      core_done_i  = nd;
      core_data_i  = nd ? ndat : rnd128();
    end
  end

  // ---------------- downstream ready driver ----------------
  int ordy_mode = 0;  // 0 always ready, 1 random, 2 held off
  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ordy_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = 1'($urandom_range(0, 1));
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [127:0]     d;
    logic             l;
    logic [CNT_W-1:0] c;
  } exp_t;
  exp_t         sb[$];
  logic [127:0] got_q[$];

  initial begin
    logic         pv, pr, pl;
    logic [127:0] pd;
    exp_t         e;
    pv = 0; pr = 0; pl = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
      end else begin
        if (core_load_key_o || core_start_enc_o || core_start_dec_o)
          check("cmd_while_core_busy", core_ready_i, 1);
        if (out_valid_o)
          check("cmd_during_output", {core_load_key_o, core_start_enc_o, core_start_dec_o}, 0);
        if (out_valid_o && !pv)
          check("output_expected", sb.size() != 0, 1);
        if (pv && !pr) begin
          check("out_valid_held", out_valid_o, 1);
          check("out_data_held", out_data_o, pd);
          check("out_last_held", out_last_o, pl);
        end
        if (out_valid_o && out_ready_i && sb.size() != 0) begin
          e = sb.pop_front();
          check("out_data", out_data_o, e.d);
          check("out_last", out_last_o, e.l);
          check("blk_count_before", blk_count_o, e.c);
          got_q.push_back(out_data_o);
        end
        pv = out_valid_o; pr = out_ready_i; pd = out_data_o; pl = out_last_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [127:0] msg_q[$];

  task automatic wait_idle(input string name);
    int i = 0;
    while (!cfg_ready_o && i < 2000) begin @(posedge clk); #1; i++; end
    check(name, cfg_ready_o, 1);
  endtask

  task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv, input bit dec, input bit cbc);
    wait_idle("idle_before_cfg");
    cfg_key_i = k; cfg_iv_i = iv; cfg_decrypt_i = dec; cfg_cbc_i = cbc; cfg_valid_i = 1'b1;
    @(posedge clk); #1;
    cfg_valid_i = 1'b0; cfg_key_i = rnd128(); cfg_iv_i = rnd128();
  endtask

  task automatic send_block(input logic [127:0] d, input bit l);
    int i = 0;
    bit acc;
    in_valid_i = 1'b1; in_data_i = d; in_last_i = l;
    do begin acc = in_ready_o; @(posedge clk); #1; i++; end while (!acc && i < 2000);
    in_valid_i = 1'b0; in_data_i = rnd128(); in_last_i = 1'b0;
    check("in_accepted", acc, 1);
  endtask

  // Reference: C_i = E(P_i ^ C_{i-1}) / P_i = D(C_i) ^ C_{i-1}, C_0 = IV; ECB skips the XOR.
  task automatic run_msg(input logic [127:0] k, input logic [127:0] iv, input bit dec, input bit cbc);
    logic [127:0] chain, x, y;
    exp_t e;
    int n = msg_q.size();
    do_cfg(k, iv, dec, cbc);
    chain = iv;
    for (int i = 0; i < n; i++) begin
      x = msg_q[i];
      if (!dec) begin
        y = cipher(k, cbc ? (x ^ chain) : x, 0);
        chain = y;
      end else begin
        y = cipher(k, x, 1);
        if (cbc) y = y ^ chain;
        chain = x;
      end
      e.d = y; e.l = (i == n - 1); e.c = CNT_W'(i);
      sb.push_back(e);
      send_block(x, i == n - 1);
    end
    wait_idle("idle_after_msg");
    check("blk_count_after_msg", blk_count_o, n);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready_o, 1);
    check({tag, "_outs_zero"}, {busy_o, in_ready_o, out_valid_o, out_last_o, err_timeout_o,
                                core_load_key_o, core_start_enc_o, core_start_dec_o}, 0);
    check({tag, "_out_data"}, out_data_o, 0);
    check({tag, "_core_data"}, core_data_o, 0);
    check({tag, "_blk_count"}, blk_count_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;

  initial begin
    int i, s0;
    int err_cyc;
    logic [127:0]     hold_d, k, iv;
    logic [CNT_W-1:0] c0;

    rst = 1'b1; cfg_valid_i = 0; cfg_key_i = '0; cfg_iv_i = '0; cfg_decrypt_i = 0; cfg_cbc_i = 0;
    in_valid_i = 0; in_data_i = '0; in_last_i = 0;
    add_vec(K1, P0, 0, C0);
    add_vec(K1, C0, 1, P0);
    add_vec(K2, P1 ^ IV2, 0, C1);
    add_vec(K2, P2 ^ C1, 0, C2);
    add_vec(K2, C1, 1, P1 ^ IV2);
    add_vec(K2, C2, 1, P2 ^ C1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("reset");

    // Known-answer vectors
    got_q.delete(); msg_q = '{P0};
    run_msg(K1, '0, 0, 0);
    check("ecb_enc_kat", (got_q.size() > 0) ? got_q[0] : '0, C0);
    got_q.delete(); msg_q = '{C0};
    run_msg(K1, '0, 1, 0);
    check("ecb_dec_kat", (got_q.size() > 0) ? got_q[0] : '0, P0);
    got_q.delete(); msg_q = '{P1, P2};
    run_msg(K2, IV2, 0, 1);
    check("cbc_enc_c1", (got_q.size() > 1) ? got_q[0] : '0, C1);
    check("cbc_enc_c2", (got_q.size() > 1) ? got_q[1] : '0, C2);
    got_q.delete(); msg_q = '{C1, C2};
    run_msg(K2, IV2, 1, 1);
    check("cbc_dec_p1", (got_q.size() > 1) ? got_q[0] : '0, P1);
    check("cbc_dec_p2", (got_q.size() > 1) ? got_q[1] : '0, P2);

    // Backpressure: hold the first result for 20 cycles
    k = rnd128(); iv = rnd128();
    ordy_mode = 2;
    do_cfg(k, iv, 0, 1);
    fork
      begin
        exp_t e;
        logic [127:0] b0, b1;
        b0 = rnd128(); b1 = rnd128();
        e.d = cipher(k, b0 ^ iv, 0); e.l = 0; e.c = 0;
        sb.push_back(e);
        send_block(b0, 0);
        e.d = cipher(k, b1 ^ e.d, 0); e.l = 1; e.c = 1;
        sb.push_back(e);
        send_block(b1, 1);
      end
      begin
        i = 0;
        while (!out_valid_o && i < 200) begin @(posedge clk); #1; i++; end
        check("bp_valid_seen", out_valid_o, 1);
        hold_d = out_data_o; s0 = n_starts; c0 = blk_count_o;
        repeat (20) begin
          @(posedge clk); #1;
          check("bp_valid", out_valid_o, 1);
          check("bp_data", out_data_o, hold_d);
          check("bp_in_ready", in_ready_o, 0);
        end
        check("bp_no_start", n_starts, s0);
        ordy_mode = 0;
        i = 0;
        while (blk_count_o == c0 && i < 20) begin @(posedge clk); #1; i++; end
        check("bp_one_transfer", blk_count_o, c0 + 1'b1);
        check("bp_valid_drops", out_valid_o, 0);
      end
    join
    wait_idle("bp_idle");
    check("bp_count", blk_count_o, 2);

    // Done arriving on the last permitted cycle still completes the block
    lat_force = T - 1;
    msg_q = '{rnd128()};
    run_msg(rnd128(), rnd128(), 0, 0);
    check("done_at_limit_no_err", err_timeout_o, 0);
    lat_force = 0;

    // Timeout: err is set on the T-th edge after the edge that captured the start
    hang = 1;
    do_cfg(rnd128(), rnd128(), 1, 1);
    s0 = n_starts;
    send_block(rnd128(), 1);
    i = 0;
    while (!err_timeout_o && i < 300) begin @(negedge clk); i++; end
    err_cyc = cyc;
    check("timeout_set", err_timeout_o, 1);
    check("timeout_started", n_starts, s0 + 1);
    check("timeout_latency", err_cyc - start_cyc, T + 1);
    @(posedge clk); #1;
    check("timeout_idle", {cfg_ready_o, busy_o}, 2'b10);
    hang = 0; inject = 1;
    repeat (6) @(posedge clk); #1;
    check("late_done_ignored", {cfg_ready_o, out_valid_o, err_timeout_o}, 3'b101);
    check("late_done_count", blk_count_o, 0);
    msg_q = '{rnd128()};
    run_msg(rnd128(), rnd128(), 0, 1);
    check("cfg_clears_err", err_timeout_o, 0);

    // Reset while waiting for the core
    hang = 1;
    do_cfg(rnd128(), rnd128(), 0, 0);
    s0 = n_starts;
    send_block(rnd128(), 1);
    i = 0;
    while (n_starts == s0 && i < 50) begin @(posedge clk); #1; i++; end
    @(posedge clk); #1;
    check("rst_mid_busy", busy_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    hang = 0; inject = 1;
    repeat (6) @(posedge clk); #1;
    check("rst_done_ignored", {cfg_ready_o, out_valid_o}, 2'b10);

    // Randomised messages
    for (int m = 0; m < 10; m++) begin
      int n;
      ordy_mode = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 4));
      msg_q.delete();
      for (int b = 0; b < n; b++) msg_q.push_back(rnd128());
      run_msg(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    ordy_mode = 0;
    wait_idle("final_idle");
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
